clock_period_monitor: RTL and testbench

- Receiving end of the divided square-wave clocks produced in gate_finder.
- Samples a slow square-wave input with the fast system clock and measures its period and high time in system-clock cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a timeout when the input stops toggling.
- Sits between a clock divider or external pin and the display/checking logic.

---
 rtl/gate_finder_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/clock_period_monitor.sv | 100 ++++++++++
 tb/tb_clock_period_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_finder_pkg.sv
// rtl/gate_finder_pkg.sv - shared state encoding and clock constants for gate_finder receivers
package gate_finder_pkg;

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      ARM      = 2'd1,
      MEAS     = 2'd2
   } state_e;

   localparam int SYS_CLK_HZ      = 50_000_000;
   // Half a second at the system clock: slowest input worth waiting for.
   localparam int DEFAULT_TIMEOUT = SYS_CLK_HZ / 2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rise/fall detection for an async input
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/clock_period_monitor.sv
// rtl/clock_period_monitor.sv - measures period and high time of a slow async clock in clk cycles
module clock_period_monitor
   import gate_finder_pkg::*;
#(
   parameter int CNT_W       = 25,
   parameter int TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FILL_CNT   = CNT_W'(SYNC_STAGES);

   logic level, rise, fall;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] hi_lat_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_q;
   logic             valid_q;
   logic             timeout_q;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_in(sig_in),
      .level   (level),
      .rise    (rise),
      .fall    (fall)
   );

   // Cycles elapsed since the last accepted rise, counting the rise cycle itself.
   assign cnt_d = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= WAIT_LOW;
         cnt_q     <= '0;
         hi_lat_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            WAIT_LOW: begin
               // A cleared synchronizer reads low before it has sampled sig_in; let it fill first.
               if (cnt_q < FILL_CNT) begin
                  cnt_q <= cnt_d;
               end else if (!level) begin
                  state_q <= ARM;
                  cnt_q   <= '0;
               end
            end
            ARM: begin
               if (rise) begin
                  state_q   <= MEAS;
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
               end
            end
            MEAS: begin
               if (rise) begin
                  period_q <= cnt_d;
                  high_q   <= hi_lat_q;
                  valid_q  <= 1'b1;
                  cnt_q    <= '0;
               end else if (cnt_q == TIMEOUT_M1) begin
                  state_q   <= ARM;
                  timeout_q <= 1'b1;
               end else begin
                  if (fall) begin
                     hi_lat_q <= cnt_d;
                  end
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= WAIT_LOW;
         endcase
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// tb/tb_clock_period_monitor.sv - self-checking bench for clock_period_monitor against an edge-time model
module tb_clock_period_monitor;

   localparam int CNT_W = 25;
   localparam int TO    = 100;
   localparam int SS    = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period, high_time, period2, high_time2;
   logic             valid, timeout, valid2, timeout2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clock_period_monitor #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in),
      .period(period), .high_time(high_time), .valid(valid), .timeout(timeout)
   );

   clock_period_monitor #(.CNT_W(CNT_W)) dut_long (
      .clk(clk), .rst(rst), .sig_in(sig_in),
      .period(period2), .high_time(high_time2), .valid(valid2), .timeout(timeout2)
   );

   typedef struct {
      int per;
      int hi;
      bit to;
   } meas_t;

   meas_t exp_q[$];
   meas_t cap_q[$];
   meas_t cap2_q[$];

   // Model: 0 = needs a low level, 1 = waiting for the arming rise, 2 = measuring.
   int tcyc = 0;
   int mstate = 0;
   int t_rise = 0;
   int t_fall = 0;

   int dbl_valid = 0;
   int unstable = 0;
   int valid_cnt = 0;
   logic rst_s;
   logic prev_valid = 1'b0;
   logic [CNT_W-1:0] prev_per = '0, prev_hi = '0;

   always @(posedge clk) begin
      tcyc++;
      rst_s = rst;
      #1;
      if (valid) begin
         cap_q.push_back('{int'(period), int'(high_time), timeout});
         valid_cnt++;
         if (prev_valid) dbl_valid++;
      end
      if (valid2) cap2_q.push_back('{int'(period2), int'(high_time2), timeout2});
      if (rst_s && !valid && (period !== prev_per || high_time !== prev_hi)) unstable++;
      prev_valid = valid;
      prev_per   = period;
      prev_hi    = high_time;
   end

   task automatic set_sig(input logic v);
      if (v !== sig_in) begin
         if (v) begin
            if (mstate == 1) begin
               mstate = 2;
               t_rise = tcyc;
            end else if (mstate == 2) begin
               if (tcyc - t_rise <= TO) exp_q.push_back('{tcyc - t_rise, t_fall - t_rise, 1'b0});
               t_rise = tcyc;
            end
         end else begin
            if (mstate == 0) mstate = 1;
            t_fall = tcyc;
         end
      end
      sig_in = v;
   endtask

   task automatic phase(input logic v, input int n);
      set_sig(v);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_reset();
      rst = 1'b1;
      mstate = sig_in ? 0 : 1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (period !== '0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
      checks++; if (high_time !== '0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_time); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", timeout); end
   endtask

   task automatic test_square();
      int n0;
      release_reset();
      repeat (6) @(negedge clk);
      n0 = valid_cnt;
      for (int i = 0; i < 6; i++) begin
         phase(1'b1, 5);
         phase(1'b0, 5);
      end
      set_sig(1'b1);
      repeat (12) @(negedge clk);
      checks++;
      if (valid_cnt - n0 != 6) begin errors++; $display("FAIL square_valid_count got %0d exp 6", valid_cnt - n0); end
      checks++;
      if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL square_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i].per !== exp_q[i].per || cap_q[i].hi !== exp_q[i].hi || cap_q[i].to !== 1'b0) begin
            errors++;
            $display("FAIL square_meas[%0d] got per=%0d hi=%0d to=%0b exp per=%0d hi=%0d to=0", i, cap_q[i].per, cap_q[i].hi, cap_q[i].to, exp_q[i].per, exp_q[i].hi);
         end
         checks++;
         if (cap_q[i].per !== 10 || cap_q[i].hi !== 5) begin
            errors++; $display("FAIL square_const[%0d] got per=%0d hi=%0d exp per=10 hi=5", i, cap_q[i].per, cap_q[i].hi);
         end
      end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_duty();
      for (int i = 0; i < 4; i++) begin
         phase(1'b0, 9);
         phase(1'b1, 3);
      end
      phase(1'b0, 9);
      set_sig(1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL duty_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i].per !== exp_q[i].per || cap_q[i].hi !== exp_q[i].hi || cap_q[i].to !== 1'b0) begin
            errors++;
            $display("FAIL duty_meas[%0d] got per=%0d hi=%0d exp per=%0d hi=%0d", i, cap_q[i].per, cap_q[i].hi, exp_q[i].per, exp_q[i].hi);
         end
      end
      checks++;
      if (cap_q.size() < 2 || cap_q[1].per !== 12 || cap_q[1].hi !== 3) begin
         errors++; $display("FAIL duty_first_changed got size=%0d exp per=12 hi=3", cap_q.size());
      end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      int h, l;
      for (int i = 0; i < 20; i++) begin
         h = $urandom_range(45, 5);
         l = $urandom_range(95 - h, 5);
         phase(1'b1, h);
         phase(1'b0, l);
      end
      set_sig(1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i].per !== exp_q[i].per || cap_q[i].hi !== exp_q[i].hi || cap_q[i].to !== 1'b0) begin
            errors++;
            $display("FAIL random_meas[%0d] got per=%0d hi=%0d exp per=%0d hi=%0d", i, cap_q[i].per, cap_q[i].hi, exp_q[i].per, exp_q[i].hi);
         end
      end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      int tr;
      phase(1'b1, 5);
      for (int i = 0; i < 3; i++) begin
         phase(1'b0, 5);
         phase(1'b1, 5);
      end
      tr = t_rise;
      set_sig(1'b0);
      while (tcyc - tr < 102) @(negedge clk);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %0b exp 0", timeout); end
      @(negedge clk);
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_fire got %0b exp 1", timeout); end
      repeat (20) @(negedge clk);
      checks++; if (period !== 10 || high_time !== 5) begin errors++; $display("FAIL timeout_hold got per=%0d hi=%0d exp per=10 hi=5", period, high_time); end
      phase(1'b1, 5);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %0b exp 0", timeout); end
      phase(1'b0, 5);
      phase(1'b1, 40);
      phase(1'b0, 60);
      phase(1'b1, 50);
      phase(1'b0, 51);
      phase(1'b1, 5);
      phase(1'b0, 5);
      set_sig(1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i].per !== exp_q[i].per || cap_q[i].hi !== exp_q[i].hi || cap_q[i].to !== 1'b0) begin
            errors++;
            $display("FAIL timeout_meas[%0d] got per=%0d hi=%0d exp per=%0d hi=%0d", i, cap_q[i].per, cap_q[i].hi, exp_q[i].per, exp_q[i].hi);
         end
      end
      checks++;
      if (cap_q.size() < 5 || cap_q[3].per !== 10 || cap_q[4].per !== 100 || cap_q[4].hi !== 40) begin
         errors++; $display("FAIL timeout_boundary got size=%0d exp restart per=10 then per=100 hi=40", cap_q.size());
      end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_held_high_reset();
      rst = 1'b0;
      sig_in = 1'b1;
      repeat (3) @(negedge clk);
      release_reset();
      repeat (7) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         phase(1'b0, 7);
         phase(1'b1, 7);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL held_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i].per !== exp_q[i].per || cap_q[i].hi !== exp_q[i].hi) begin
            errors++;
            $display("FAIL held_meas[%0d] got per=%0d hi=%0d exp per=%0d hi=%0d", i, cap_q[i].per, cap_q[i].hi, exp_q[i].per, exp_q[i].hi);
         end
      end
      checks++;
      if (cap_q.size() != 3 || cap_q[0].per !== 14 || cap_q[0].hi !== 7) begin
         errors++; $display("FAIL held_first got size=%0d exp size=3 per=14 hi=7", cap_q.size());
      end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      phase(1'b0, 6);
      phase(1'b1, 6);
      phase(1'b0, 3);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs got per=%0d hi=%0d v=%0b to=%0b exp all 0", period, high_time, valid, timeout);
      end
      cap_q.delete(); exp_q.delete();
      release_reset();
      phase(1'b0, 6);
      for (int i = 0; i < 3; i++) begin
         phase(1'b1, 6);
         phase(1'b0, 6);
      end
      set_sig(1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if (cap_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL mid_count got %0d exp 3 (model %0d)", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i].per !== 12 || cap_q[i].hi !== 6 || cap_q[i].per !== exp_q[i].per) begin
            errors++; $display("FAIL mid_meas[%0d] got per=%0d hi=%0d exp per=12 hi=6", i, cap_q[i].per, cap_q[i].hi);
         end
      end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_long();
      int n;
      cap2_q.delete();
      for (int i = 0; i < 3; i++) begin
         phase(1'b0, 1001);
         phase(1'b1, 1001);
      end
      set_sig(1'b0);
      repeat (10) @(negedge clk);
      n = cap2_q.size();
      checks++;
      if (n < 2) begin
         errors++; $display("FAIL long_count got %0d exp >=2", n);
      end else begin
         for (int i = n - 2; i < n; i++) begin
            checks++;
            if (cap2_q[i].per !== 2002 || cap2_q[i].hi !== 1001 || cap2_q[i].to !== 1'b0) begin
               errors++; $display("FAIL long_meas[%0d] got per=%0d hi=%0d to=%0b exp per=2002 hi=1001 to=0", i, cap2_q[i].per, cap2_q[i].hi, cap2_q[i].to);
            end
         end
      end
      checks++; if (timeout2 !== 1'b0) begin errors++; $display("FAIL long_timeout got %0b exp 0", timeout2); end
      checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL long_short_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
      cap_q.delete(); exp_q.delete();
   endtask

   task automatic test_integrity();
      checks++; if (dbl_valid != 0) begin errors++; $display("FAIL valid_width got %0d back-to-back strobes exp 0", dbl_valid); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL output_stability got %0d changes without valid exp 0", unstable); end
   endtask

   initial begin
      test_reset();
      test_square();
      test_duty();
      test_random();
      test_timeout();
      test_held_high_reset();
      test_reset_mid();
      test_long();
      test_integrity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
